// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : lsu_dmem_ctrl
// Brief    : M-stage load/store unit with byte-lane data RAM, sign/zero load
//            extension and optional wait states with pipeline stall.
//            Macro LSU_MISALIGN_TRAP_EN: flag misaligned requests instead of
//            silently aligning them.
// Revision : 1.0  initial release
// =============================================================================
module lsu_dmem_ctrl #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReqM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] AddrM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            MemStallM,
  output logic            MemDoneM,
  output logic            MisalignM
);

  localparam int AW     = $clog2(DEPTH_WORDS);
  localparam int BW     = AW + 2;
  localparam int NLANES = XLEN / 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Decode of the request currently presented on the inputs
  logic            cur_ld_ok;
  logic            cur_st_ok;
  logic            cur_trap;
  logic            cur_access;
  logic [BW-1:0]   cur_addr;

  // Access actually committing this cycle (live inputs or latched request)
  logic            acc_go;
  logic            acc_we;
  logic [2:0]      acc_f3;
  logic [BW-1:0]   acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [NLANES-1:0] acc_be;
  logic [XLEN-1:0] acc_lane_data;

  logic [XLEN-1:0] rd_word;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] rd_ext;

  logic [XLEN-1:0] ram [DEPTH_WORDS];

  // Address bits above the RAM window wrap and are deliberately dropped
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, AddrM[XLEN-1:BW]};

  always_comb begin
    cur_ld_ok = !MemWriteM && (Funct3M inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    cur_st_ok = MemWriteM && (Funct3M inside {3'b000, 3'b001, 3'b010});
    cur_trap  = 1'b0;
    cur_addr  = AddrM[BW-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    case (Funct3M[1:0])
      2'b01:   cur_trap = AddrM[0];
      2'b10:   cur_trap = AddrM[1] | AddrM[0];
      default: cur_trap = 1'b0;
    endcase
    cur_trap = cur_trap & MemReqM & (cur_ld_ok | cur_st_ok);
`else
    case (Funct3M[1:0])
      2'b01:   cur_addr[0]   = 1'b0;
      2'b10:   cur_addr[1:0] = 2'b00;
      default: ;
    endcase
`endif
    cur_access = MemReqM & (cur_ld_ok | cur_st_ok) & ~cur_trap;
  end

  generate
    if (WAIT_STATES == 0) begin : g_no_wait
      always_comb begin
        acc_go    = cur_access & ~reset;
        acc_we    = MemWriteM;
        acc_f3    = Funct3M;
        acc_addr  = cur_addr;
        acc_wdata = WriteDataM;
        MemStallM = 1'b0;
        MemDoneM  = MemReqM & ~reset;
        MisalignM = cur_trap & ~reset;
      end
    end else begin : g_wait
      localparam logic [3:0] C_CNT_LOAD = 4'(WAIT_STATES - 1);

      state_t          state_q, state_d;
      logic [3:0]      cnt_q, cnt_d;
      logic            req_we_q, req_we_d;
      logic [2:0]      req_f3_q, req_f3_d;
      logic [BW-1:0]   req_addr_q, req_addr_d;
      logic [XLEN-1:0] req_wdata_q, req_wdata_d;

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          req_we_q    <= 1'b0;
          req_f3_q    <= '0;
          req_addr_q  <= '0;
          req_wdata_q <= '0;
        end else begin
          state_q     <= state_d;
          cnt_q       <= cnt_d;
          req_we_q    <= req_we_d;
          req_f3_q    <= req_f3_d;
          req_addr_q  <= req_addr_d;
          req_wdata_q <= req_wdata_d;
        end
      end

      always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_we_d    = req_we_q;
        req_f3_d    = req_f3_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        MemStallM   = 1'b0;
        MemDoneM    = 1'b0;
        MisalignM   = 1'b0;
        acc_go      = 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (MemReqM) begin
              if (cur_access) begin
                // Latch the request so later input wiggles cannot corrupt it
                MemStallM   = 1'b1;
                cnt_d       = C_CNT_LOAD;
                state_d     = ST_WAIT;
                req_we_d    = MemWriteM;
                req_f3_d    = Funct3M;
                req_addr_d  = cur_addr;
                req_wdata_d = WriteDataM;
              end else begin
                MemDoneM  = 1'b1;
                MisalignM = cur_trap;
              end
            end
          end
          ST_WAIT: begin
            if (cnt_q != 4'd0) begin
              MemStallM = 1'b1;
              cnt_d     = cnt_q - 4'd1;
            end else begin
              MemDoneM = 1'b1;
              acc_go   = 1'b1;
              state_d  = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (reset) begin
          MemStallM = 1'b0;
          MemDoneM  = 1'b0;
          MisalignM = 1'b0;
          acc_go    = 1'b0;
        end
        acc_we    = req_we_q;
        acc_f3    = req_f3_q;
        acc_addr  = req_addr_q;
        acc_wdata = req_wdata_q;
      end
    end
  endgenerate

  // Store lane enables and data replicated across lanes
  always_comb begin
    acc_be        = '0;
    acc_lane_data = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        acc_be[acc_addr[1:0]] = 1'b1;
        acc_lane_data         = {NLANES{acc_wdata[7:0]}};
      end
      2'b01: begin
        acc_be[{acc_addr[1], 1'b0} +: 2] = 2'b11;
        acc_lane_data                    = {(NLANES/2){acc_wdata[15:0]}};
      end
      default: acc_be = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (acc_go && acc_we) begin
      for (int b = 0; b < NLANES; b++) begin
        if (acc_be[b]) begin
          ram[acc_addr[BW-1:2]][8*b +: 8] <= acc_lane_data[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_word = ram[acc_addr[BW-1:2]];
    rd_byte = rd_word[{acc_addr[1:0], 3'b000} +: 8];
    rd_half = acc_addr[1] ? rd_word[16 +: 16] : rd_word[0 +: 16];
    case (acc_f3)
      3'b000:  rd_ext = {{(XLEN-8){rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{(XLEN-16){rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {{(XLEN-8){1'b0}}, rd_byte};
      3'b101:  rd_ext = {{(XLEN-16){1'b0}}, rd_half};
      default: rd_ext = rd_word;
    endcase
    ReadDataM = (acc_go && !acc_we) ? rd_ext : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// Bench for lsu_dmem_ctrl: a zero-wait and a three-wait instance driven with
// directed and random accesses, checked against a byte-array memory model.
module tb_lsu_dmem_ctrl;

  localparam int D0  = 1024;
  localparam int D3  = 64;
  localparam int WS3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, req0, we0, stall0, done0, mis0;
  logic [2:0]  f3_0;
  logic [31:0] addr0, wd0, rd0;
  logic        rst3, req3, we3, stall3, done3, mis3;
  logic [2:0]  f3_3;
  logic [31:0] addr3, wd3, rd3;

  lsu_dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(D0), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(rst0), .MemReqM(req0), .MemWriteM(we0), .Funct3M(f3_0),
    .AddrM(addr0), .WriteDataM(wd0), .ReadDataM(rd0), .MemStallM(stall0),
    .MemDoneM(done0), .MisalignM(mis0));

  lsu_dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(D3), .WAIT_STATES(WS3)) u_dut3 (
    .clk(clk), .reset(rst3), .MemReqM(req3), .MemWriteM(we3), .Funct3M(f3_3),
    .AddrM(addr3), .WriteDataM(wd3), .ReadDataM(rd3), .MemStallM(stall3),
    .MemDoneM(done3), .MisalignM(mis3));

  logic [7:0] m0 [D0*4];
  logic [7:0] m3 [D3*4];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mrd(input bit sel3, input int a);
    return sel3 ? m3[a] : m0[a];
  endfunction

  task automatic mstore(input bit sel3, input int base, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < (1 << f3[1:0]); i++) begin
      if (sel3) m3[base+i] = wd[8*i +: 8];
      else      m0[base+i] = wd[8*i +: 8];
    end
  endtask

  // Byte-addressed little-endian memory; access size is 1<<funct3[1:0] bytes
  function automatic void model(input bit sel3, input bit we, input logic [2:0] f3,
                                input logic [31:0] addr, output bit acc, output bit trap,
                                output logic [31:0] rd, output int base);
    int  nb, span, a;
    bit  valid;
    span  = sel3 ? D3*4 : D0*4;
    valid = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    nb    = 1 << f3[1:0];
    a     = int'(addr % 32'(span));
    trap  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = valid && (a % nb != 0);
`else
    a = a - (a % nb);
`endif
    acc  = valid && !trap;
    base = a;
    rd   = 32'd0;
    if (acc && !we) begin
      for (int i = nb - 1; i >= 0; i--) rd = (rd << 8) | 32'(mrd(sel3, a + i));
      if (!f3[2] && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8*nb)) - 32'd1);
    end
  endfunction

  task automatic op0(input string tag, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] obs);
    bit acc, trap;
    logic [31:0] rd;
    int base;
    model(1'b0, we, f3, addr, acc, trap, rd, base);
    req0 = 1'b1; we0 = we; f3_0 = f3; addr0 = addr; wd0 = wd;
    @(negedge clk);
    check({tag, ".stall"}, {31'd0, stall0}, 32'd0);
    check({tag, ".done"},  {31'd0, done0},  32'd1);
    check({tag, ".mis"},   {31'd0, mis0},   {31'd0, trap});
    check({tag, ".rdata"}, rd0, rd);
    obs = rd0;
    @(posedge clk);
    if (acc && we) mstore(1'b0, base, f3, wd);
    #1 req0 = 1'b0;
  endtask

  task automatic op3(input string tag, input bit we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] obs);
    bit acc, trap;
    logic [31:0] rd;
    int base;
    model(1'b1, we, f3, addr, acc, trap, rd, base);
    req3 = 1'b1; we3 = we; f3_3 = f3; addr3 = addr; wd3 = wd;
    if (acc) begin
      for (int c = 0; c < WS3; c++) begin
        @(negedge clk);
        check({tag, $sformatf(".stall%0d", c)}, {31'd0, stall3}, 32'd1);
        check({tag, $sformatf(".done%0d", c)},  {31'd0, done3},  32'd0);
        @(posedge clk);
        #1;
        // The latched request must win over whatever the inputs do now
        we3 = 1'($urandom_range(0, 1)); f3_3 = 3'($urandom_range(0, 7));
        addr3 = $urandom(); wd3 = $urandom();
      end
    end
    @(negedge clk);
    check({tag, ".stall"}, {31'd0, stall3}, 32'd0);
    check({tag, ".done"},  {31'd0, done3},  32'd1);
    check({tag, ".mis"},   {31'd0, mis3},   {31'd0, trap});
    check({tag, ".rdata"}, rd3, rd);
    obs = rd3;
    @(posedge clk);
    if (acc && we) mstore(1'b1, base, f3, wd);
    #1 req3 = 1'b0;
  endtask

  task automatic idle_check0(input string tag);
    req0 = 1'b0;
    @(negedge clk);
    check({tag, ".done"},  {31'd0, done0}, 32'd0);
    check({tag, ".rdata"}, rd0, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] obs;
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; f3_0 = 3'd0; addr0 = '0; wd0 = '0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; f3_3 = 3'd0; addr3 = '0; wd3 = '0;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    check("rst0.stall", {31'd0, stall0}, 32'd0);
    check("rst0.done",  {31'd0, done0},  32'd0);
    check("rst0.mis",   {31'd0, mis0},   32'd0);
    check("rst0.rdata", rd0, 32'd0);
    check("rst3.stall", {31'd0, stall3}, 32'd0);
    check("rst3.done",  {31'd0, done3},  32'd0);
    check("rst3.mis",   {31'd0, mis3},   32'd0);
    check("rst3.rdata", rd3, 32'd0);
    @(posedge clk);
    #1;

    // Give every RAM word a known value before any load
    for (int w = 0; w < D0; w++) op0("fill0", 1'b1, 3'b010, 32'(w*4), $urandom(), obs);
    for (int w = 0; w < D3; w++) op3("fill3", 1'b1, 3'b010, 32'(w*4), $urandom(), obs);

    op0("t1.sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, obs);
    op0("t1.lw", 1'b0, 3'b010, 32'h10, 32'h0, obs);
    check("t1.value", obs, 32'hDEADBEEF);

    op0("t2.sw",  1'b1, 3'b010, 32'h10, 32'h11223344, obs);
    op0("t2.sb",  1'b1, 3'b000, 32'h13, 32'h00000080, obs);
    op0("t2.lb",  1'b0, 3'b000, 32'h13, 32'h0, obs);
    check("t2.lb.value", obs, 32'hFFFFFF80);
    op0("t2.lbu", 1'b0, 3'b100, 32'h13, 32'h0, obs);
    check("t2.lbu.value", obs, 32'h00000080);
    op0("t2.lw",  1'b0, 3'b010, 32'h10, 32'h0, obs);
    check("t2.lw.value", obs, 32'h80223344);

    op0("t3.sw",  1'b1, 3'b010, 32'h20, 32'h0, obs);
    op0("t3.sh",  1'b1, 3'b001, 32'h22, 32'h0000BEEF, obs);
    op0("t3.lh",  1'b0, 3'b001, 32'h22, 32'h0, obs);
    check("t3.lh.value", obs, 32'hFFFFBEEF);
    op0("t3.lhu", 1'b0, 3'b101, 32'h22, 32'h0, obs);
    check("t3.lhu.value", obs, 32'h0000BEEF);
    op0("t3.lw",  1'b0, 3'b010, 32'h20, 32'h0, obs);
    check("t3.lw.value", obs, 32'hBEEF0000);

    op0("t6.lw", 1'b0, 3'b010, 32'h12, 32'h0, obs);
`ifdef LSU_MISALIGN_TRAP_EN
    check("t6.trap.value", obs, 32'h0);
`else
    check("t6.legacy.value", obs, 32'h80223344);
`endif

    op3("t4.sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, obs);
    op3("t4.lw", 1'b0, 3'b010, 32'h10, 32'h0, obs);
    check("t4.value", obs, 32'hDEADBEEF);
    @(negedge clk);
    check("t4.idle.stall", {31'd0, stall3}, 32'd0);
    check("t4.idle.done",  {31'd0, done3},  32'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of a waited store must drop it
    op3("t5.pre", 1'b1, 3'b010, 32'h40, 32'h11111111, obs);
    req3 = 1'b1; we3 = 1'b1; f3_3 = 3'b010; addr3 = 32'h40; wd3 = 32'hCAFEF00D;
    @(negedge clk);
    check("t5.stall0", {31'd0, stall3}, 32'd1);
    @(posedge clk);
    #1 rst3 = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b0; req3 = 1'b0;
    @(negedge clk);
    check("t5.after.stall", {31'd0, stall3}, 32'd0);
    check("t5.after.done",  {31'd0, done3},  32'd0);
    @(posedge clk);
    #1;
    op3("t5.lw", 1'b0, 3'b010, 32'h40, 32'h0, obs);
    check("t5.prior", obs, 32'h11111111);

    for (int n = 0; n < 300; n++) begin
      op0("rnd0", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), obs);
      if ($urandom_range(0, 3) == 0) idle_check0("rnd0.idle");
    end
    for (int n = 0; n < 150; n++) begin
      op3("rnd3", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(), obs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
